// File: rtl/uart_receiver_top_module.sv
// 16x oversampling 8N1 UART receiver with a 2-flop RX synchronizer and register-style
// holding/status outputs (data_ready, framing_error, overrun, busy).
module uart_receiver_top_module #(
    parameter logic [31:0] clock_frequency_register = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Baud_Rate_Holding_Register,
    input  logic        RX,
    input  logic        Receiver_Read,
    output logic [31:0] Receiver_Holding_Register,
    output logic [31:0] Receiver_Status
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_prev_q, rx_prev_d;
    logic [31:0] div_q, div_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]  samp_cnt_q, samp_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        data_ready_q, data_ready_d;
    logic        framing_q, framing_d;
    logic        overrun_q, overrun_d;
    logic        busy_q, busy_d;
    logic        wait_high_q, wait_high_d;

    logic [31:0] div_raw, div_calc;
    logic        tick, start_edge, complete;

    // Baud values of 2^28 and above would overflow 16*baud; any such rate is far above
    // the system clock anyway, so they fall through to the clamped divisor of 1.
    always_comb begin
        div_raw = 32'd0;
        if (Baud_Rate_Holding_Register != 32'd0 && Baud_Rate_Holding_Register[31:28] == 4'd0) begin
            div_raw = clock_frequency_register / {Baud_Rate_Holding_Register[27:0], 4'b0000};
        end
        div_calc = (div_raw == 32'd0) ? 32'd1 : div_raw;
    end

    always_comb begin
        state_d      = state_q;
        rx_meta_d    = RX;
        rx_s_d       = rx_meta_q;
        rx_prev_d    = rx_s_q;
        div_d        = div_q;
        tick_cnt_d   = tick_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_ready_d = data_ready_q;
        framing_d    = framing_q;
        overrun_d    = overrun_q;
        busy_d       = busy_q;
        wait_high_d  = wait_high_q;
        complete     = 1'b0;
        tick         = (tick_cnt_q == div_q - 32'd1);
        start_edge   = rx_prev_q && !rx_s_q && !wait_high_q;

        if (Baud_Rate_Holding_Register == 32'd0) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            tick_cnt_d = 32'd0;
        end else begin
            if (state_q != IDLE) begin
                tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (rx_s_q) begin
                        wait_high_d = 1'b0;
                    end
                    // The divisor is latched here so a baud change only applies to the next frame.
                    if (start_edge) begin
                        state_d    = START;
                        div_d      = div_calc;
                        tick_cnt_d = 32'd0;
                        samp_cnt_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                        busy_d     = 1'b1;
                    end
                end
                START: begin
                    if (tick && samp_cnt_q == 4'd7) begin
                        samp_cnt_d = 4'd0;
                        if (rx_s_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick && samp_cnt_q == 4'd15) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick && samp_cnt_q == 4'd15) begin
                        state_d  = IDLE;
                        complete = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A read coinciding with completion acknowledges the old byte; the new frame wins.
        if (complete) begin
            data_d       = shift_q;
            data_ready_d = 1'b1;
            framing_d    = !rx_s_q;
            wait_high_d  = !rx_s_q;
            busy_d       = 1'b0;
            if (Receiver_Read) begin
                overrun_d = 1'b0;
            end else if (data_ready_q) begin
                overrun_d = 1'b1;
            end
        end else if (Receiver_Read) begin
            data_ready_d = 1'b0;
            framing_d    = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_q        <= 32'd0;
            tick_cnt_q   <= 32'd0;
            samp_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            data_q       <= 8'd0;
            data_ready_q <= 1'b0;
            framing_q    <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            wait_high_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            div_q        <= div_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
            framing_q    <= framing_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            wait_high_q  <= wait_high_d;
        end
    end

    assign Receiver_Holding_Register = {24'd0, data_q};
    assign Receiver_Status           = {28'd0, busy_q, overrun_q, framing_q, data_ready_q};

endmodule

// File: doc/uart_receiver_top_module.md
Name: uart_receiver_top_module

Overview:
UART receive path and the counterpart of the transmitter top module. It samples the serial RX line at 16x oversampling, using a tick rate derived from the programmed baud rate and the system clock frequency. It deframes 8N1 characters, LSB first, and presents each byte with status flags in 32-bit register-style outputs for the bus interface.

Parameters:
clock_frequency_register, 'd100_000_000, system clock frequency in Hz used for the baud divisor

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
Baud_Rate_Holding_Register  input  32  baud rate in bits/s; 0 = receiver disabled
RX  input  1  asynchronous serial input; idle high
Receiver_Read  input  1  single-cycle pulse; host has consumed the holding register
Receiver_Holding_Register  output  32  [7:0] last received byte, [31:8] always 0
Receiver_Status  output  32  [0] data_ready, [1] framing_error, [2] overrun, [3] busy, [31:4] always 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. All state and outputs are zero on the cycle after rst is sampled high. The RX synchronizer flops are forced to 1 during reset.
- Reset mid-frame aborts the frame: no data loaded, no flags changed except clearing.
- RX input: 2-flop synchronizer, so 2 clk latency. The FSM uses only the synchronized value (rx_s).
- Divisor: clock_frequency_register / (16 * Baud_Rate_Holding_Register), integer truncation, 32-bit unsigned.
  - A result of 0 is clamped to 1.
  - Baud_Rate_Holding_Register == 0: tick generation halts and the FSM is held in IDLE.
- Tick counter: counts 0..divisor-1 and emits a 1-clk tick at wrap. It restarts from 0 on start-edge detection.
- Baud change: a new baud value takes effect at the next start edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: watch for a falling edge on rx_s (previous 1, current 0). On the edge, go to START, zero the tick and bit counters, and set busy.
  - START: after 8 ticks (mid start bit), sample rx_s.
    - 1: false start, return to IDLE with no flag change.
    - 0: go to DATA, tick count 0.
  - DATA: every 16 ticks, sample rx_s into shift register bit [n], n = 0..7, LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample rx_s, then return to IDLE the next cycle.
- Frame completion: on the cycle after the stop sample:
  - Receiver_Holding_Register[7:0] <= shifted byte.
  - data_ready <= 1.
  - framing_error <= (stop sample == 0).
  - busy <= 0.
- Framing error: data is still loaded and data_ready is still set. After a low stop bit, IDLE requires rx_s to be seen high before it accepts a new falling edge, so a held-low line (break) generates one framed-error character only.
- Receiver_Read, no simultaneous completion: clears data_ready, framing_error and overrun on the next cycle. The data byte is retained.
- Frame completes while data_ready == 1 and Receiver_Read == 0: overrun <= 1 and the byte is overwritten.
- Receiver_Read in the same cycle as completion: the read applies to the old byte and the new completion wins. data_ready stays 1, overrun is not set, framing_error reflects the new frame.
- Latency: data_ready rises 1 clk after the stop-bit mid-sample. That is about 9.5 bit periods after the start edge, plus 2 synchronizer clocks.
- busy is high from start-edge detection until frame completion or false-start rejection.

Test Plan:
1. Parameter default, baud = 6_250_000 (divisor 1, bit = 16 clk): send 0xA5 → Receiver_Holding_Register = 0x000000A5, Status = 0x1, data_ready rises about 154 clk after the start edge.
2. Baud = 115200 (divisor 54, bit = 864 clk): send 0x3C then pulse Receiver_Read → byte 0x3C, Status goes 0x1 → 0x0, Holding register stays 0x3C.
3. Send 0x55 with the stop bit driven low → Status = 0x3 (data_ready + framing_error), byte = 0x55. Hold RX low for 20 bit times → no second character until RX returns high.
4. Send 0x11 then 0x22 with no read → Status = 0x5, byte = 0x22. Assert Receiver_Read in the exact completion cycle of a third byte 0x33 → Status = 0x1, no overrun.
5. Pulse RX low for 4 bit-clocks only (divisor 1) → false start: busy pulses then clears, Status stays 0, no data loaded.
6. Assert rst mid-DATA of 0xFF → all outputs 0 next cycle, FSM in IDLE. A subsequent 0x0F is received correctly. With baud = 0, toggling RX → Status stays 0.
